io_bus_arbiter: RTL and testbench

//  Shares the single processor IO/memory bus between two requesters: m0 is the CPU data port and m1 is the debug/DMA port.

---
 rtl/io_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares one IO/memory target bus between two requesters (m0 = CPU data
//   port, m1 = debug/DMA port). Round-robin arbitration with a single
//   transaction in flight; strobes are held until s_ack, and an optional
//   timeout turns a missing ack into an error response.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   mX_req/we/addr/wdata (X=0,1)    request and its attributes, sampled in IDLE
//   mX_gnt                          one-cycle pulse: request accepted
//   mX_done/err/rdata               one-cycle completion, error flag, read data
//   s_addr/s_wdata/s_we/s_re        registered target bus, strobes held in ACCESS
//   s_ack/s_rdata                   target completion and read data
module io_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_we,
  output logic              s_re,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata
);

  // A zero-width counter is illegal, so keep one bit when the timeout is off.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_last_q, rr_last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic              s_we_q, s_we_d;
  logic              s_re_q, s_re_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              sel;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_we_d    = s_we_q;
    s_re_d    = s_re_q;
    gnt_d     = '0;
    done_d    = '0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    sel       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the requester that did not finish last wins.
          sel       = (m0_req && m1_req) ? ~rr_last_q : m1_req;
          owner_d   = sel;
          s_addr_d  = sel ? m1_addr  : m0_addr;
          s_wdata_d = sel ? m1_wdata : m0_wdata;
          s_we_d    = sel ? m1_we    : m0_we;
          s_re_d    = ~(sel ? m1_we : m0_we);
          cnt_d     = '0;
          gnt_d     = sel ? 2'b10 : 2'b01;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (s_ack) begin
          rdata_d = s_re_q ? s_rdata : '0;
          err_d   = 1'b0;
          s_re_d  = 1'b0;
          s_we_d  = 1'b0;
          done_d  = owner_q ? 2'b10 : 2'b01;
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          s_re_d  = 1'b0;
          s_we_d  = 1'b0;
          done_d  = owner_q ? 2'b10 : 2'b01;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rr_last_d = owner_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_we_q    <= 1'b0;
      s_re_q    <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_we_q    <= s_we_d;
      s_re_q    <= s_re_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Response fields are only visible to the owner, and only with done.
  assign m0_gnt   = gnt_q[0];
  assign m1_gnt   = gnt_q[1];
  assign m0_done  = done_q[0];
  assign m1_done  = done_q[1];
  assign m0_err   = done_q[0] & err_q;
  assign m1_err   = done_q[1] & err_q;
  assign m0_rdata = done_q[0] ? rdata_q : '0;
  assign m1_rdata = done_q[1] ? rdata_q : '0;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_we     = s_we_q;
  assign s_re     = s_re_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
`timescale 1ns/1ps
module tb_io_bus_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        s_we, s_re;
  logic        s_ack = 1'b0;
  logic [31:0] s_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  io_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_re(s_re),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Target responder: ack after ack_wait strobe cycles (-1 = never), or random.
  int          ack_wait  = 0;
  bit          ack_rand  = 0;
  int          ack_pct   = 50;
  bit          late_ack  = 0;
  logic [31:0] rdata_fix = '0;
  int          acc_n     = 0;

  always @(negedge clk) begin
    if (s_re || s_we) begin
      if (ack_rand) s_ack = ($urandom_range(99) < ack_pct);
      else          s_ack = (ack_wait >= 0 && acc_n == ack_wait);
      acc_n++;
    end else begin
      acc_n = 0;
      s_ack = ack_rand ? ($urandom_range(99) < ack_pct) : late_ack;
    end
    s_rdata = ack_rand ? $urandom : rdata_fix;
  end

  // Transaction-timeline model: age counts cycles since the accept edge,
  // fin is the age of the done cycle once the access has ended (-1 before).
  bit          mb  = 0;
  bit          mo  = 0;
  bit          mrr = 1;
  bit          mw  = 0;
  bit          me  = 0;
  int          ma  = 0;
  int          mf  = -1;
  logic [31:0] mad = '0, mwd = '0, mrd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb  <= 0;
      mrr <= 1;
    end else if (!mb) begin
      if (m0_req || m1_req) begin
        automatic bit who = (m0_req && m1_req) ? !mrr : m1_req;
        mo  <= who;
        mw  <= who ? m1_we : m0_we;
        mad <= who ? m1_addr : m0_addr;
        mwd <= who ? m1_wdata : m0_wdata;
        mb  <= 1;
        ma  <= 0;
        mf  <= -1;
      end
    end else if (mf < 0) begin
      if (s_ack) begin
        mf  <= ma + 1;
        me  <= 0;
        mrd <= mw ? 32'h0 : s_rdata;
      end else if (TO != 0 && ma == TO - 1) begin
        mf  <= ma + 1;
        me  <= 1;
        mrd <= '0;
      end
      ma <= ma + 1;
    end else begin
      mb  <= 0;
      mrr <= mo;
    end
  end

  always @(negedge clk) begin
    automatic bit g   = mb && (ma == 0);
    automatic bit d   = mb && (mf >= 0);
    automatic bit acc = mb && (mf < 0);
    automatic logic [7:0] exp_c = {g && mo, g && !mo, d && mo, d && !mo,
                                   d && mo && me, d && !mo && me, acc && !mw, acc && mw};
    chk("ctrl{g1,g0,d1,d0,e1,e0,re,we}",
        {m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err, s_re, s_we}, exp_c);
    chk("m0_rdata", m0_rdata, (d && !mo) ? mrd : 32'h0);
    chk("m1_rdata", m1_rdata, (d && mo) ? mrd : 32'h0);
    if (acc) begin
      chk("s_addr", s_addr, mad);
      chk("s_wdata", s_wdata, mwd);
    end
  end

  task automatic wait_gnt(input int m, input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (m == 0 ? m0_gnt : m1_gnt) begin
        waited = i;
        break;
      end
    end
    if (waited < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL gnt_wait: m%0d got no grant, required one within %0d cycles", m, budget);
    end
  endtask

  initial begin
    int w, n, got, stable, ng, nm1g, td1, tg0, cyc;
    int who[6];
    int when[6];

    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, s_re, s_we,
                          s_addr, s_wdata}, '0);
    @(negedge clk);
    rst_n = 1;

    // 1) m0 read, zero-wait ack
    rdata_fix = 32'hDEADBEEF;
    ack_wait = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    wait_gnt(0, 5, w);
    chk("t1_gnt_latency", w, 1);
    chk("t1_sre", s_re, 1);
    chk("t1_saddr", s_addr, 32'h100);
    m0_req = 0;
    @(negedge clk);
    chk("t1_done", m0_done, 1);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_err", m0_err, 0);
    chk("t1_sre_off", s_re, 0);
    @(negedge clk);

    // 2) both requesting continuously
    m0_req = 1; m1_req = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) begin
        who[ng]  = m1_gnt ? 1 : 0;
        when[ng] = c;
        ng++;
      end
    end
    chk("t2_grant_count", ng, 6);
    if (ng == 6) begin
      chk("t2_first_m1", who[0], 1);
      for (int k = 1; k < 6; k++) begin
        chk("t2_alternate", who[k], who[k-1] ^ 1);
        chk("t2_spacing", when[k] - when[k-1], 3);
      end
    end
    m0_req = 0; m1_req = 0;
    repeat (6) @(negedge clk);

    // 3) m1 write with three wait cycles
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h5A5A5A5A;
    ack_wait = 3;
    wait_gnt(1, 10, w);
    m1_req = 0;
    n = 0; got = 0; stable = 1;
    for (int i = 0; i < 30 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (s_we) begin
        n++;
        if (s_addr !== 32'h200 || s_wdata !== 32'h5A5A5A5A) stable = 0;
      end
      if (m1_done) begin
        got = 1;
        chk("t3_err", m1_err, 0);
        chk("t3_rdata", m1_rdata, 32'h0);
      end
    end
    chk("t3_done_seen", got, 1);
    chk("t3_we_cycles", n, 4);
    chk("t3_addr_data_stable", stable, 1);
    m1_we = 0;

    // 4) timeout, then a late ack
    m0_req = 1; m0_we = 0; m0_addr = 32'h400;
    ack_wait = -1;
    wait_gnt(0, 10, w);
    m0_req = 0;
    n = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (s_re) n++;
      if (m0_done) begin
        got = 1;
        chk("t4_err", m0_err, 1);
        chk("t4_rdata", m0_rdata, 32'h0);
      end
    end
    chk("t4_done_seen", got, 1);
    chk("t4_re_cycles", n, TO);
    late_ack = 1;
    repeat (2) @(negedge clk);
    late_ack = 0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      n += int'(m0_done) + int'(m1_done);
    end
    chk("t4_late_ack_ignored", n, 0);

    // 5) reset in the middle of ACCESS
    m0_req = 1; m0_addr = 32'h500;
    wait_gnt(0, 10, w);
    m0_req = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("t5_sre_async", s_re, 0);
    chk("t5_no_done_at_reset", {m0_done, m1_done}, 2'b00);
    repeat (2) begin
      @(negedge clk);
      chk("t5_no_done_in_reset", {m0_done, m1_done}, 2'b00);
    end
    rst_n = 1;
    ack_wait = 0;
    m0_req = 1; m1_req = 1;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (m0_gnt || m1_gnt) begin
        got = 1;
        chk("t5_first_tie_m0", {m1_gnt, m0_gnt}, 2'b01);
      end
    end
    chk("t5_grant_seen", got, 1);
    m0_req = 0; m1_req = 0;
    repeat (6) @(negedge clk);

    // 6) m1 drops req after gnt, m0 arrives mid-ACCESS
    ack_wait = 3;
    m1_req = 1; m1_we = 0; m1_addr = 32'h300;
    wait_gnt(1, 10, w);
    m1_req = 0;
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h304;
    td1 = -1; tg0 = -1; nm1g = 0;
    for (cyc = 0; cyc < 16; cyc++) begin
      if (m1_gnt) nm1g++;
      if (m1_done && td1 < 0) td1 = cyc;
      if (m0_gnt && tg0 < 0) begin
        tg0 = cyc;
        m0_req = 0;
      end
      @(negedge clk);
    end
    chk("t6_m1_done_seen", td1 >= 0, 1);
    chk("t6_m0_gnt_after_done", tg0 - td1, 2);
    chk("t6_no_spurious_m1", nm1g, 0);
    repeat (4) @(negedge clk);

    // Random traffic, checked every cycle against the model
    ack_rand = 1;
    for (int b = 0; b < 6; b++) begin
      ack_pct = (b % 3 == 0) ? 50 : (b % 3 == 1) ? 10 : 2;
      repeat (500) begin
        @(negedge clk);
        m0_req   = ($urandom_range(2) == 0);
        m1_req   = ($urandom_range(2) == 0);
        m0_we    = $urandom_range(1);
        m1_we    = $urandom_range(1);
        m0_addr  = $urandom;
        m1_addr  = $urandom;
        m0_wdata = $urandom;
        m1_wdata = $urandom;
      end
    end
    m0_req = 0; m1_req = 0;
    ack_rand = 0; ack_wait = 0;
    repeat (25) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
